pwm_ramp_controller: RTL and testbench

Sequencer and configuration front-end for the 3-bit PWM datapath. Owns the PWM period counter and the duty compare, and accepts new duty targets over a valid/ready command port. Ramps the live duty one step at a time toward the target, on period boundaries only, giving glitch-free duty changes and soft start. Sits between the control logic that issues duty commands and the PWM output pin.

---
 rtl/pwm_ramp_controller.sv | 123 ++++++++++++
 tb/tb_pwm_ramp_controller.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_ramp_controller.sv
// PWM period counter and duty compare with a valid/ready duty port.
// Live duty ramps one LSB per STEP_PERIODS periods, only at period wrap.
module pwm_ramp_controller #(
  parameter int WIDTH        = 3,
  parameter int STEP_PERIODS = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic             cmd_valid,
  input  logic [WIDTH:0]   cmd_duty,
  output logic             cmd_ready,
  output logic             pwm_out,
  output logic [WIDTH-1:0] cnt,
  output logic [WIDTH:0]   duty_now,
  output logic             busy,
  output logic             period_end
);

  localparam int SW = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;
  localparam logic [WIDTH:0]   FULL  = {1'b1, {WIDTH{1'b0}}};
  localparam logic [WIDTH-1:0] CMAX  = '1;
  localparam logic [SW-1:0]    SLAST = SW'(STEP_PERIODS - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    RAMP
  } state_t;

  state_t          state;
  logic [WIDTH:0]  target;
  logic [WIDTH:0]  pend;
  logic            pend_v;
  logic [SW-1:0]   step_cnt;

  logic            accept;
  logic            active;
  logic            boundary;
  logic [WIDTH:0]  sat;
  logic [WIDTH:0]  duty_nxt;
  logic [WIDTH:0]  tgt_nxt;
  logic [SW-1:0]   step_nxt;

  always_comb begin
    accept   = cmd_valid && !pend_v;
    active   = (state != IDLE);
    boundary = active && (cnt == CMAX);
    sat      = (cmd_duty > FULL) ? FULL : cmd_duty;
    tgt_nxt  = pend_v ? pend : target;
  end

  // Ramp step as seen at a boundary, judged against the pre-boundary target.
  always_comb begin
    duty_nxt = duty_now;
    step_nxt = step_cnt;
    unique case (1'b1)
      (duty_now == target): step_nxt = '0;
      (step_cnt == SLAST): begin
        step_nxt = '0;
        duty_nxt = (target > duty_now) ? duty_now + 1'b1
                                       : duty_now - 1'b1;
      end
      default: step_nxt = step_cnt + 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state    <= IDLE;
      cnt      <= '0;
      duty_now <= '0;
      target   <= '0;
      pend     <= '0;
      pend_v   <= 1'b0;
      step_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) target <= sat;
          if (en) begin
            if ((accept ? sat : target) != duty_now) state <= RAMP;
            else                                     state <= RUN;
          end
        end
        RUN, RAMP: begin
          if (!en) begin
            state    <= IDLE;
            cnt      <= '0;
            duty_now <= '0;
            step_cnt <= '0;
            if (pend_v) begin
              target <= pend;
              pend_v <= 1'b0;
            end else if (accept) begin
              target <= sat;
            end
          end else begin
            cnt <= cnt + 1'b1;
            if (accept) begin
              pend   <= sat;
              pend_v <= 1'b1;
            end
            if (boundary) begin
              duty_now <= duty_nxt;
              step_cnt <= step_nxt;
              target   <= tgt_nxt;
              if (pend_v) pend_v <= 1'b0;
              state <= (duty_nxt == tgt_nxt) ? RUN : RAMP;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign cmd_ready  = !pend_v;
  assign pwm_out    = active && ({1'b0, cnt} < duty_now);
  assign busy       = (state == RAMP);
  assign period_end = boundary;

endmodule

// File: tb/tb_pwm_ramp_controller.sv
// Directed bench for pwm_ramp_controller (WIDTH=3, STEP_PERIODS=2)
// with a per-cycle reference model and literal checkpoints.
module tb_pwm_ramp_controller;

  localparam int W  = 3;
  localparam int SP = 2;
  localparam int P  = 1 << W;

  logic         clk = 1'b0;
  logic         clr;
  logic         en;
  logic         cmd_valid;
  logic [W:0]   cmd_duty;
  logic         cmd_ready;
  logic         pwm_out;
  logic [W-1:0] cnt;
  logic [W:0]   duty_now;
  logic         busy;
  logic         period_end;

  int n_vec = 0;
  int n_err = 0;

  pwm_ramp_controller #(.WIDTH(W), .STEP_PERIODS(SP)) dut (
    .clk        (clk),
    .clr        (clr),
    .en         (en),
    .cmd_valid  (cmd_valid),
    .cmd_duty   (cmd_duty),
    .cmd_ready  (cmd_ready),
    .pwm_out    (pwm_out),
    .cnt        (cnt),
    .duty_now   (duty_now),
    .busy       (busy),
    .period_end (period_end)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic timeout(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s: timed out at %0t", nm, $time);
  endtask

  // Reference model: enabled flag, period position, live duty, target,
  // a one-deep command slot and the count of off-target periods.
  bit m_ok = 0;
  bit m_on;
  int m_cnt, m_duty, m_tgt, m_steps;
  int m_pend[$];

  always @(posedge clk) begin
    int s;
    bit acc, wrap;
    if (clr) begin
      m_ok = 1; m_on = 0; m_cnt = 0; m_duty = 0;
      m_tgt = 0; m_steps = 0; m_pend.delete();
    end else if (m_ok) begin
      acc = cmd_valid && (m_pend.size() == 0);
      s   = (int'(cmd_duty) > P) ? P : int'(cmd_duty);
      if (!m_on) begin
        if (acc) m_tgt = s;
        if (en) m_on = 1;
      end else if (!en) begin
        m_on = 0; m_cnt = 0; m_duty = 0; m_steps = 0;
        if (m_pend.size() != 0) m_tgt = m_pend.pop_front();
        else if (acc) m_tgt = s;
      end else begin
        wrap  = (m_cnt == P - 1);
        m_cnt = (m_cnt + 1) % P;
        if (wrap) begin
          if (m_duty == m_tgt) m_steps = 0;
          else if (m_steps == SP - 1) begin
            m_duty += (m_tgt > m_duty) ? 1 : -1;
            m_steps = 0;
          end else m_steps++;
          if (m_pend.size() != 0) m_tgt = m_pend.pop_front();
        end
        if (acc) m_pend.push_back(s);
      end
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      chk("m_cnt", 32'(cnt), m_cnt);
      chk("m_duty", 32'(duty_now), m_duty);
      chk("m_pwm", 32'(pwm_out), 32'(m_on && (m_cnt < m_duty)));
      chk("m_busy", 32'(busy), 32'(m_on && (m_duty != m_tgt)));
      chk("m_pend", 32'(period_end), 32'(m_on && (m_cnt == P - 1)));
      chk("m_ready", 32'(cmd_ready), 32'(m_pend.size() == 0));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [W:0] v);
    bit done = 0;
    cmd_valid = 1'b1;
    cmd_duty  = v;
    for (int i = 0; i < 200 && !done; i++) begin
      if (cmd_ready) done = 1;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    if (!done) timeout("send");
  endtask

  task automatic settle();
    bit done = 0;
    for (int i = 0; i < 1000 && !done; i++) begin
      if (cmd_ready && !busy) done = 1;
      else @(negedge clk);
    end
    if (!done) timeout("settle");
  endtask

  task automatic wait_cnt(input int v);
    bit done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (int'(cnt) == v) done = 1;
      else @(negedge clk);
    end
    if (!done) timeout("wait_cnt");
  endtask

  initial begin
    bit done;
    clr = 1'b1; en = 1'b0; cmd_valid = 1'b0; cmd_duty = '0;
    cyc(3);
    chk("rst_cnt", 32'(cnt), 0);
    chk("rst_duty", 32'(duty_now), 0);
    chk("rst_ready", 32'(cmd_ready), 1);
    chk("rst_pwm", 32'(pwm_out), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_pe", 32'(period_end), 0);
    clr = 1'b0;

    // Soft start toward 3
    send(4'd3);
    chk("idle_ready", 32'(cmd_ready), 1);
    en = 1'b1;
    cyc(1);
    chk("ss_cnt0", 32'(cnt), 0);
    chk("ss_busy", 32'(busy), 1);
    cyc(1);
    chk("ss_cnt1", 32'(cnt), 1);
    cyc(14);
    chk("ss_d0", 32'(duty_now), 0);
    cyc(1);
    chk("ss_d1", 32'(duty_now), 1);
    cyc(31);
    chk("ss_d2", 32'(duty_now), 2);
    chk("ss_busy2", 32'(busy), 1);
    cyc(1);
    chk("ss_d3", 32'(duty_now), 3);
    chk("ss_busy3", 32'(busy), 0);
    for (int i = 0; i < P; i++) begin
      chk("ss_pcnt", 32'(cnt), i);
      chk("ss_pwm", 32'(pwm_out), 32'(i < 3));
      cyc(1);
    end

    // Extremes and saturation
    send(4'd0);
    settle();
    chk("ex_d0", 32'(duty_now), 0);
    for (int i = 0; i < P; i++) begin
      chk("ex_low", 32'(pwm_out), 0);
      cyc(1);
    end
    send(4'd15);
    settle();
    chk("ex_d8", 32'(duty_now), 8);
    for (int i = 0; i < P; i++) begin
      chk("ex_high", 32'(pwm_out), 1);
      cyc(1);
    end

    // Back-to-back commands with CMD_VALID held
    wait_cnt(3);
    cmd_valid = 1'b1;
    cmd_duty  = 4'd5;
    cyc(1);
    chk("hs_ready0", 32'(cmd_ready), 0);
    cmd_duty = 4'd2;
    done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (period_end) done = 1;
      else cyc(1);
    end
    if (!done) timeout("hs_bnd");
    cyc(1);
    chk("hs_ready1", 32'(cmd_ready), 1);
    chk("hs_busy", 32'(busy), 1);
    cyc(1);
    chk("hs_ready2", 32'(cmd_ready), 0);
    cmd_valid = 1'b0;
    settle();
    chk("hs_d2", 32'(duty_now), 2);

    // Command landing on the wrap clock
    wait_cnt(7);
    cmd_valid = 1'b1;
    cmd_duty  = 4'd4;
    cyc(1);
    cmd_valid = 1'b0;
    chk("br_busy0", 32'(busy), 0);
    chk("br_ready0", 32'(cmd_ready), 0);
    cyc(8);
    chk("br_busy1", 32'(busy), 1);
    chk("br_ready1", 32'(cmd_ready), 1);
    settle();
    send(4'd3);
    settle();
    chk("br_d3", 32'(duty_now), 3);

    // Disable mid-period and soft restart
    wait_cnt(4);
    en = 1'b0;
    cyc(1);
    chk("dis_cnt", 32'(cnt), 0);
    chk("dis_pwm", 32'(pwm_out), 0);
    chk("dis_duty", 32'(duty_now), 0);
    chk("dis_busy", 32'(busy), 0);
    en = 1'b1;
    cyc(1);
    chk("re_busy", 32'(busy), 1);
    cyc(16);
    chk("re_d1", 32'(duty_now), 1);

    // Reset in the middle of a ramp toward 6
    send(4'd6);
    done = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      if (duty_now == 2 && busy) done = 1;
      else cyc(1);
    end
    if (!done) timeout("rr_wait");
    clr = 1'b1;
    en  = 1'b0;
    cyc(1);
    clr = 1'b0;
    chk("rr_cnt", 32'(cnt), 0);
    chk("rr_duty", 32'(duty_now), 0);
    chk("rr_ready", 32'(cmd_ready), 1);
    chk("rr_busy", 32'(busy), 0);
    chk("rr_pe", 32'(period_end), 0);
    for (int i = 0; i < 12; i++) begin
      chk("rr_pwm", 32'(pwm_out), 0);
      cyc(1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
